// File: rtl/mult_hilo_ctrl_pkg.sv
// rtl/mult_hilo_ctrl_pkg.sv - shared pipeline definitions for the HI/LO multiply sequencer
package mult_hilo_ctrl_pkg;

    localparam int OP_W_DEF = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_CLEAR = S_CLEAR,
        ST_RUN   = S_RUN,
        ST_WRITE = S_WRITE
    } mhc_state_t;

endpackage

// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - EX-stage sequencer for the Booth multiplier and the HI/LO register pair
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ex_mult/ex_mfhi/ex_mflo  decoded EX instruction
//   rs_val, rt_val           forwarded operands
//   mul_start, mul_a, mul_b  multiplier control and operands
//   mul_ready, mul_result    multiplier done flag and signed product
//   stall                    freeze PC/IF/ID/EX
//   hilo_rdata               HI or LO for MFHI/MFLO, zero otherwise
//   mul_err                  sticky multiplier timeout flag
module mult_hilo_ctrl
    import mult_hilo_ctrl_pkg::*;
#(
    parameter int OP_W     = OP_W_DEF,
    parameter int WAIT_MAX = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mult,
    input  logic              ex_mfhi,
    input  logic              ex_mflo,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic              mul_ready,
    input  logic [2*OP_W-1:0] mul_result,
    output logic              stall,
    output logic [31:0]       hilo_rdata,
    output logic              mul_err
);

    localparam int P_W   = 2 * OP_W;
    localparam int CNT_W = $clog2(WAIT_MAX + 2);

    mhc_state_t       state, state_next;
    logic [CNT_W-1:0] run_cnt;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      hi_new, lo_new;
    logic             abort_q;
    logic             launch, write_hilo, timeout_hit;
    logic             ready_ok, timeout;
    logic             unused_upper;

    assign unused_upper = ^{rs_val[31:OP_W], rt_val[31:OP_W]};

    assign lo_new = 32'($signed(mul_result));
    assign hi_new = {32{mul_result[P_W-1]}};

    // The done flag is left over from the previous operation for the first
    // RUN cycles, so it only counts from run_cnt == 2 onwards.
    assign ready_ok = mul_ready && (run_cnt >= CNT_W'(2));
    assign timeout  = (run_cnt == CNT_W'(WAIT_MAX));

    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        write_hilo  = 1'b0;
        timeout_hit = 1'b0;
        mul_start   = 1'b0;
        stall       = 1'b0;
        case (state)
            ST_IDLE: begin
                // After a timeout the aborted MULT is still sitting in EX;
                // abort_q lets it retire instead of relaunching.
                if (ex_mult && !abort_q && rst_n) begin
                    launch     = 1'b1;
                    stall      = 1'b1;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                stall      = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                mul_start = 1'b1;
                stall     = 1'b1;
                if (ready_ok) begin
                    state_next = ST_WRITE;
                end else if (timeout) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Stall is released here so the MULT retires on the same
                // edge that updates HI/LO.
                mul_start  = 1'b1;
                write_hilo = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            run_cnt <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_err <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_next;
            abort_q <= timeout_hit;
            if (timeout_hit) begin
                mul_err <= 1'b1;
            end
            if (launch) begin
                mul_a <= rs_val[OP_W-1:0];
                mul_b <= rt_val[OP_W-1:0];
            end
            if (state == ST_CLEAR) begin
                run_cnt <= '0;
            end else if (state == ST_RUN && state_next == ST_RUN) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
            if (write_hilo) begin
                hi_q <= hi_new;
                lo_q <= lo_new;
            end
        end
    end

    // In WRITE the product bypasses the registers so a read held behind the
    // multiply sees the new value on the cycle it is released.
    always_comb begin
        hilo_rdata = 32'd0;
        if (ex_mfhi) begin
            hilo_rdata = (state == ST_WRITE) ? hi_new : hi_q;
        end else if (ex_mflo) begin
            hilo_rdata = (state == ST_WRITE) ? lo_new : lo_q;
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb/tb_mult_hilo_ctrl.sv - directed-vector bench for mult_hilo_ctrl
module tb_mult_hilo_ctrl;

    localparam int OP_W = 16;
    localparam int LAT  = 18;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_mult, ex_mfhi, ex_mflo;
    logic [31:0]       rs_val, rt_val;
    logic              mul_start;
    logic [OP_W-1:0]   mul_a, mul_b;
    logic              mul_ready;
    logic [2*OP_W-1:0] mul_result;
    logic              stall;
    logic [31:0]       hilo_rdata;
    logic              mul_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic        tie_zero = 1'b0;
    logic        stale_en = 1'b0;
    logic [4:0]  m_cnt    = '0;
    logic        m_done   = 1'b0;
    logic [31:0] m_prod   = '0;

    always #5 clk = ~clk;

    mult_hilo_ctrl #(.OP_W(OP_W), .WAIT_MAX(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_mult    (ex_mult),
        .ex_mfhi    (ex_mfhi),
        .ex_mflo    (ex_mflo),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ready  (mul_ready),
        .mul_result (mul_result),
        .stall      (stall),
        .hilo_rdata (hilo_rdata),
        .mul_err    (mul_err)
    );

    // Behavioural multiplier: cleared while start is low, done LAT cycles after start rises.
    always @(posedge clk) begin
        if (!mul_start) begin
            m_cnt  <= '0;
            m_done <= 1'b0;
        end else begin
            if (m_cnt != 5'd31) m_cnt <= m_cnt + 5'd1;
            if (m_cnt == 5'(LAT - 1)) begin
                m_done <= 1'b1;
                m_prod <= $signed(mul_a) * $signed(mul_b);
            end
        end
    end

    assign mul_ready  = !tie_zero && (m_done || (stale_en && mul_start && m_cnt < 5'd2));
    assign mul_result = m_prod;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a MULT and hold it in EX until stall drops, then retire it.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            output int n, output logic [15:0] ca, output logic [15:0] cb);
        rs_val  = a;
        rt_val  = b;
        ex_mult = 1'b1;
        n = 0;
        ca = '0;
        cb = '0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                ca = mul_a;
                cb = mul_b;
            end
        end while (stall && n < 100);
        chk("mult_retire_stall", {31'd0, stall}, 32'd0);
        tick();
        ex_mult = 1'b0;
    endtask

    task automatic rd(input bit hi, input string tag, input logic [31:0] exp);
        ex_mfhi = hi;
        ex_mflo = !hi;
        #1;
        chk(tag, hilo_rdata, exp);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        ex_mfhi = 1'b0;
        ex_mflo = 1'b0;
        tick();
    endtask

    initial begin
        int          n;
        logic [15:0] ca, cb;

        rst_n   = 1'b0;
        ex_mult = 1'b0;
        ex_mfhi = 1'b0;
        ex_mflo = 1'b0;
        rs_val  = '0;
        rt_val  = '0;
        repeat (3) tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_start", {31'd0, mul_start}, 32'd0);
        chk("rst_err", {31'd0, mul_err}, 32'd0);
        chk("rst_a", {16'd0, mul_a}, 32'd0);
        chk("rst_b", {16'd0, mul_b}, 32'd0);
        rst_n = 1'b1;
        tick();
        rd(1'b1, "rst_hi", 32'd0);
        rd(1'b0, "rst_lo", 32'd0);

        // 7 * -3
        run_mult(32'd7, 32'hFFFF_FFFD, n, ca, cb);
        chk("t1_stall_len", n, 32'd21);
        chk("t1_mul_a", {16'd0, ca}, 32'h0000_0007);
        chk("t1_mul_b", {16'd0, cb}, 32'h0000_FFFD);
        rd(1'b0, "t1_lo", 32'hFFFF_FFEB);
        rd(1'b1, "t1_hi", 32'hFFFF_FFFF);

        // 0x7FFF * 0x7FFF
        run_mult(32'h7FFF, 32'h7FFF, n, ca, cb);
        rd(1'b0, "t2_lo", 32'h3FFF_0001);
        rd(1'b1, "t2_hi", 32'h0000_0000);

        // MFHI arriving while -100 * 50 is running
        rs_val  = 32'hFFFF_FF9C;
        rt_val  = 32'd50;
        ex_mult = 1'b1;
        repeat (5) tick();
        ex_mult = 1'b0;
        ex_mfhi = 1'b1;
        #1;
        chk("t3_run_stall", {31'd0, stall}, 32'd1);
        n = 0;
        while (stall && n < 100) begin
            tick();
            n++;
        end
        chk("t3_released", {31'd0, stall}, 32'd0);
        chk("t3_in_write", {31'd0, mul_start}, 32'd1);
        chk("t3_bypass_hi", hilo_rdata, 32'hFFFF_FFFF);
        ex_mfhi = 1'b0;
        ex_mflo = 1'b1;
        #1;
        chk("t3_bypass_lo", hilo_rdata, 32'hFFFF_EC78);
        ex_mflo = 1'b0;
        tick();
        rd(1'b0, "t3_lo", 32'hFFFF_EC78);

        // MFHI wins over MFLO; neither gives zero
        ex_mfhi = 1'b1;
        ex_mflo = 1'b1;
        #1;
        chk("t4_both", hilo_rdata, 32'hFFFF_FFFF);
        ex_mfhi = 1'b0;
        ex_mflo = 1'b0;
        #1;
        chk("t4_none", hilo_rdata, 32'd0);
        tick();

        // Back-to-back 2*3 then 4*5, second one sees a stale ready flag
        run_mult(32'd2, 32'd3, n, ca, cb);
        rd(1'b0, "t5_lo_a", 32'd6);
        stale_en = 1'b1;
        run_mult(32'd4, 32'd5, n, ca, cb);
        stale_en = 1'b0;
        chk("t5_stall_len_b", n, 32'd21);
        rd(1'b0, "t5_lo_b", 32'd20);
        rd(1'b1, "t5_hi_b", 32'd0);

        // Reset during RUN
        rs_val  = 32'd5;
        rt_val  = 32'd5;
        ex_mult = 1'b1;
        repeat (6) tick();
        chk("t6_running", {31'd0, mul_start}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_start", {31'd0, mul_start}, 32'd0);
        chk("t6_rst_stall", {31'd0, stall}, 32'd0);
        ex_mult = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd(1'b1, "t6_hi", 32'd0);
        rd(1'b0, "t6_lo", 32'd0);

        // Timeout with ready tied low
        run_mult(32'd2, 32'd3, n, ca, cb);
        tie_zero = 1'b1;
        run_mult(32'd9, 32'd9, n, ca, cb);
        tie_zero = 1'b0;
        chk("t7_stall_len", n, 32'd27);
        chk("t7_err", {31'd0, mul_err}, 32'd1);
        chk("t7_start", {31'd0, mul_start}, 32'd0);
        rd(1'b0, "t7_lo", 32'd6);
        rd(1'b1, "t7_hi", 32'd0);
        chk("t7_err_sticky", {31'd0, mul_err}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
